// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM states, ALU op codes,
// instruction field constants and datapath mux encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
    ADDR, MEM_RD, MEM_WR, WB_LD, BRANCH, JUMP, HALT
  } state_t;

  // ALU operation codes, matching the ula OP input
  localparam logic [3:0] ALU_SLL  = 4'h0;
  localparam logic [3:0] ALU_SRL  = 4'h1;
  localparam logic [3:0] ALU_SRA  = 4'h2;
  localparam logic [3:0] ALU_SLLV = 4'h3;
  localparam logic [3:0] ALU_SRLV = 4'h4;
  localparam logic [3:0] ALU_SRAV = 4'h5;
  localparam logic [3:0] ALU_ADD  = 4'h6;
  localparam logic [3:0] ALU_SUB  = 4'h7;
  localparam logic [3:0] ALU_AND  = 4'h8;
  localparam logic [3:0] ALU_OR   = 4'h9;
  localparam logic [3:0] ALU_XOR  = 4'hA;
  localparam logic [3:0] ALU_NOR  = 4'hB;
  localparam logic [3:0] ALU_SLT  = 4'hC;
  localparam logic [3:0] ALU_SLTU = 4'hD;
  localparam logic [3:0] ALU_LUI  = 4'hE;
  localparam logic [3:0] ALU_ORI  = 4'hF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFS = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_alu_imm(input logic [5:0] op);
    return (op[5:3] == 3'b001);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps R-type funct or I-type opcode to the ALU operation, immediate extension mode
// and an illegal-encoding flag.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic       is_rtype,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       imm_zext,
  output logic       illegal
);

  always_comb begin
    alu_op   = ALU_ADD;
    imm_zext = 1'b0;
    illegal  = 1'b0;
    if (is_rtype) begin
      case (funct)
        FN_SLL:          alu_op = ALU_SLL;
        FN_SRL:          alu_op = ALU_SRL;
        FN_SRA:          alu_op = ALU_SRA;
        FN_SLLV:         alu_op = ALU_SLLV;
        FN_SRLV:         alu_op = ALU_SRLV;
        FN_SRAV:         alu_op = ALU_SRAV;
        FN_ADD, FN_ADDU: alu_op = ALU_ADD;
        FN_SUB, FN_SUBU: alu_op = ALU_SUB;
        FN_AND:          alu_op = ALU_AND;
        FN_OR:           alu_op = ALU_OR;
        FN_XOR:          alu_op = ALU_XOR;
        FN_NOR:          alu_op = ALU_NOR;
        FN_SLT:          alu_op = ALU_SLT;
        FN_SLTU:         alu_op = ALU_SLTU;
        default:         illegal = 1'b1;
      endcase
    end else begin
      // Logical immediates are zero-extended, everything else sign-extended
      case (opcode)
        OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
        OP_SLTI:           alu_op = ALU_SLT;
        OP_SLTIU:          alu_op = ALU_SLTU;
        OP_ANDI: begin alu_op = ALU_AND; imm_zext = 1'b1; end
        OP_ORI:  begin alu_op = ALU_OR;  imm_zext = 1'b1; end
        OP_XORI: begin alu_op = ALU_XOR; imm_zext = 1'b1; end
        OP_LUI:            alu_op = ALU_LUI;
        default:           illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath strobes, counts retired instructions and halts on illegal encodings.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             imm_zext,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted
);

  state_t     state, next_state;
  logic [3:0] dec_alu_op;
  logic       dec_zext;
  logic       dec_illegal;

  alu_op_decode u_alu_op_decode (
    .is_rtype (state == EXEC_R),
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_alu_op),
    .imm_zext (dec_zext),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (instr_done)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   next_state = FETCH;
      FETCH:  if (mem_ack) next_state = DECODE;
      DECODE: begin
        if (opcode == OP_RTYPE)                     next_state = EXEC_R;
        else if (is_alu_imm(opcode))                next_state = EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW) next_state = ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) next_state = BRANCH;
        else if (opcode == OP_J)                    next_state = JUMP;
        else                                        next_state = HALT;
      end
      EXEC_R: next_state = dec_illegal ? HALT : WB_R;
      EXEC_I: next_state = dec_illegal ? HALT : WB_I;
      ADDR:   next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: if (mem_ack) next_state = WB_LD;
      MEM_WR: if (mem_ack) next_state = FETCH;
      WB_R, WB_I, WB_LD, BRANCH, JUMP: next_state = FETCH;
      HALT:   next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    imm_zext   = 1'b0;
    alu_op     = ALU_SLL;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      DECODE: begin
        alu_src_b = SRCB_BOFS;
        alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = dec_alu_op;
        imm_zext  = dec_zext;
      end
      WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEM_WR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_we     = 1'b1;
        instr_done = mem_ack;
      end
      WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = (opcode == OP_BEQ) ? zero : !zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl: per-cycle strobes, instruction
// latencies with memory wait states, branch conditions, halt and asynchronous reset.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, imm_zext, instr_done, halted;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_op;
  logic [31:0] instr_count;

  int errors = 0;
  int checks = 0;

  wire [19:0] all_outs = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
                          mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op, pc_src,
                          instr_done, halted};

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_zext    (imm_zext),
    .alu_op      (alu_op),
    .pc_src      (pc_src),
    .instr_done  (instr_done),
    .instr_count (instr_count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fd;
    int         md;
    int         cyc;
    logic [3:0] ret;
    logic [1:0] psrc;
    logic [3:0] aop;
    logic       zx;
  } vec_t;

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH, acking memory after fd/md wait cycles; returns
  // latency (-1 on timeout) and what was seen on the retire and first execute cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fd, input int md, output int cycles,
                           output int mem_cycles, output logic [3:0] ret,
                           output logic [1:0] psrc, output logic [3:0] exec_op,
                           output logic zx);
    int wait_n = 0;
    bit done   = 0;
    bit got_op = 0;
    opcode = op; funct = fn; zero = z;
    cycles = -1; mem_cycles = 0; ret = '0; psrc = '0; exec_op = '0; zx = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (mem_req) begin
        mem_ack = (wait_n >= (iord ? md : fd));
        wait_n  = mem_ack ? 0 : wait_n + 1;
        if (iord) mem_cycles++;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if (alu_src_a && !got_op) begin
        exec_op = alu_op;
        got_op  = 1;
      end
      zx = zx | imm_zext;
      if (instr_done) begin
        done   = 1;
        cycles = c;
        ret    = {reg_write, reg_dst, mem_to_reg, pc_write};
        psrc   = pc_src;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = i[0];
      #1;
      checks++;
      if (all_outs !== 20'h0 || instr_count !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_outs cycle %0d: outs=%h count=%0d, want outs=0 count=0",
                 i, all_outs, instr_count);
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    #1;
    checks++;
    if (all_outs !== 20'h0) begin
      errors++;
      $display("[TB] FAIL idle_outs: outs=%h, want 0", all_outs);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || alu_op !== 4'h6 || alu_src_b !== 2'd1 || iord !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_entry: req=%b op=%h srcb=%0d iord=%b, want 1 6 1 0",
               mem_req, alu_op, alu_src_b, iord);
    end
  endtask

  task automatic test_add();
    opcode = 6'h00; funct = 6'h20; mem_ack = 1'b1;
    #1;
    checks++;
    if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'd0 || instr_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_fetch: irw=%b pcw=%b pcsrc=%0d done=%b, want 1 1 0 0",
               ir_write, pc_write, pc_src, instr_done);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (alu_src_a !== 1'b0 || alu_src_b !== 2'd3 || alu_op !== 4'h6 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_decode: srca=%b srcb=%0d op=%h req=%b, want 0 3 6 0",
               alu_src_a, alu_src_b, alu_op, mem_req);
    end
    @(negedge clk);
    checks++;
    if (alu_src_a !== 1'b1 || alu_src_b !== 2'd0 || alu_op !== 4'h6 || reg_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_exec: srca=%b srcb=%0d op=%h regw=%b, want 1 0 6 0",
               alu_src_a, alu_src_b, alu_op, reg_write);
    end
    @(negedge clk);
    checks++;
    if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0 || instr_done !== 1'b1
        || instr_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL add_wb: regw=%b dst=%b m2r=%b done=%b count=%0d, want 1 1 0 1 0",
               reg_write, reg_dst, mem_to_reg, instr_done, instr_count);
    end
    @(negedge clk);
    checks++;
    if (instr_count !== 32'd1 || instr_done !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_retired: count=%0d done=%b req=%b, want 1 0 1",
               instr_count, instr_done, mem_req);
    end
  endtask

  task automatic test_lw();
    int cyc, mcyc;
    logic [3:0] ret, aop;
    logic [1:0] ps;
    logic zx;
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, cyc, mcyc, ret, ps, aop, zx);
    checks++;
    if (cyc !== 8 || mcyc !== 4) begin
      errors++;
      $display("[TB] FAIL lw_timing: cycles=%0d memreq_cycles=%0d, want 8 4", cyc, mcyc);
    end
    checks++;
    if (ret !== 4'b1010 || aop !== 4'h6) begin
      errors++;
      $display("[TB] FAIL lw_wb: strobes=%b addr_op=%h, want 1010 6", ret, aop);
    end
  endtask

  task automatic test_branch();
    int cyc, mcyc;
    logic [3:0] ret, aop;
    logic [1:0] ps;
    logic zx;
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, cyc, mcyc, ret, ps, aop, zx);
    checks++;
    if (cyc !== 3 || ret !== 4'b0001 || ps !== 2'd1 || aop !== 4'h7) begin
      errors++;
      $display("[TB] FAIL beq_taken: cycles=%0d strobes=%b pcsrc=%0d op=%h, want 3 0001 1 7",
               cyc, ret, ps, aop);
    end
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, cyc, mcyc, ret, ps, aop, zx);
    checks++;
    if (cyc !== 3 || ret !== 4'b0000 || ps !== 2'd1) begin
      errors++;
      $display("[TB] FAIL bne_not_taken: cycles=%0d strobes=%b pcsrc=%0d, want 3 0000 1",
               cyc, ret, ps);
    end
    checks++;
    if (instr_count !== 32'd4) begin
      errors++;
      $display("[TB] FAIL branch_count: count=%0d, want 4", instr_count);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[11];
    int cyc, mcyc;
    logic [3:0] ret, aop;
    logic [1:0] ps;
    logic zx;
    v[0]  = '{6'h08, 6'h00, 1'b0, 0, 0, 4, 4'b1000, 2'd0, 4'h6, 1'b0};
    v[1]  = '{6'h0D, 6'h00, 1'b0, 0, 0, 4, 4'b1000, 2'd0, 4'h9, 1'b1};
    v[2]  = '{6'h0F, 6'h00, 1'b0, 0, 0, 4, 4'b1000, 2'd0, 4'hE, 1'b0};
    v[3]  = '{6'h00, 6'h22, 1'b0, 0, 0, 4, 4'b1100, 2'd0, 4'h7, 1'b0};
    v[4]  = '{6'h00, 6'h2A, 1'b0, 0, 0, 4, 4'b1100, 2'd0, 4'hC, 1'b0};
    v[5]  = '{6'h00, 6'h00, 1'b0, 0, 0, 4, 4'b1100, 2'd0, 4'h0, 1'b0};
    v[6]  = '{6'h2B, 6'h00, 1'b0, 0, 1, 5, 4'b0000, 2'd0, 4'h6, 1'b0};
    v[7]  = '{6'h02, 6'h00, 1'b0, 0, 0, 3, 4'b0001, 2'd2, 4'h0, 1'b0};
    v[8]  = '{6'h00, 6'h20, 1'b0, 2, 0, 6, 4'b1100, 2'd0, 4'h6, 1'b0};
    v[9]  = '{6'h05, 6'h00, 1'b0, 0, 0, 3, 4'b0001, 2'd1, 4'h7, 1'b0};
    v[10] = '{6'h0C, 6'h00, 1'b0, 0, 0, 4, 4'b1000, 2'd0, 4'h8, 1'b1};
    for (int i = 0; i < 11; i++) begin
      run_instr(v[i].op, v[i].fn, v[i].z, v[i].fd, v[i].md, cyc, mcyc, ret, ps, aop, zx);
      checks++;
      if (cyc !== v[i].cyc || ret !== v[i].ret || ps !== v[i].psrc || aop !== v[i].aop
          || zx !== v[i].zx) begin
        errors++;
        $display("[TB] FAIL seq[%0d] op=%h fn=%h: cyc=%0d strb=%b pcsrc=%0d aluop=%h zext=%b, want %0d %b %0d %h %b",
                 i, v[i].op, v[i].fn, cyc, ret, ps, aop, zx,
                 v[i].cyc, v[i].ret, v[i].psrc, v[i].aop, v[i].zx);
      end
    end
    checks++;
    if (instr_count !== 32'd15) begin
      errors++;
      $display("[TB] FAIL seq_count: count=%0d, want 15", instr_count);
    end
  endtask

  task automatic test_reset_mid_access();
    opcode = 6'h2B; funct = 6'h00; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || iord !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sw_wait: req=%b we=%b iord=%b, want 1 1 1", mem_req, mem_we, iord);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_count !== 32'd0 || instr_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: req=%b count=%0d done=%b, want 0 0 0",
               mem_req, instr_count, instr_done);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_hold: outs=%h, want 0", all_outs);
    end
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || iord !== 1'b0 || instr_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL refetch: req=%b we=%b iord=%b count=%0d, want 1 0 0 0",
               mem_req, mem_we, iord, instr_count);
    end
  endtask

  task automatic test_halt();
    int cyc, mcyc;
    logic [3:0] ret, aop;
    logic [1:0] ps;
    logic zx;
    // Illegal funct reaches HALT through EXEC_R
    do_reset();
    opcode = 6'h00; funct = 6'h01; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== 20'h1) begin
      errors++;
      $display("[TB] FAIL halt_funct: outs=%h, want 00001", all_outs);
    end
    do_reset();
    run_instr(6'h0E, 6'h00, 1'b0, 0, 0, cyc, mcyc, ret, ps, aop, zx);
    checks++;
    if (cyc !== 4 || aop !== 4'hA || zx !== 1'b1) begin
      errors++;
      $display("[TB] FAIL xori: cyc=%0d op=%h zext=%b, want 4 A 1", cyc, aop, zx);
    end
    opcode = 6'h3F; funct = 6'h00; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL halt_opcode: halted=%b, want 1", halted);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0];
      #1;
      checks++;
      if (all_outs !== 20'h1 || instr_count !== 32'd1) begin
        errors++;
        $display("[TB] FAIL halt_absorb cycle %0d: outs=%h count=%0d, want 00001 1",
                 i, all_outs, instr_count);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_back_to_back();
    test_reset_mid_access();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control unit sequencing the 32-bit MIPS-subset datapath built around the `ula` ALU. Each instruction moves through fetch, decode, execute, memory and write-back states, and the block drives the ALU `OP` code plus all datapath mux and enable strobes. A one-port memory is reached through a req/ack handshake. The block counts retired instructions and halts on an illegal encoding.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `opcode`  in  6: IR[31:26], valid from DECODE onward.
- `funct`  in  6: IR[5:0].
- `zero`  in  1: ALU `Zero_flag`.
- `mem_ack`  in  1: memory completed the current access this cycle.
- `mem_req`  out  1: memory access request, held until `mem_ack`.
- `mem_we`  out  1: write when 1, read when 0; valid with `mem_req`.
- `iord`  out  1: address source, 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `reg_write`  out  1 each: register enables.
- `reg_dst`  out  1: destination, 0 = rt, 1 = rd.
- `mem_to_reg`  out  1: write-back data, 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1: 0 = PC, 1 = regA.
- `alu_src_b`  out  2: 0 = regB, 1 = constant 4, 2 = extended imm, 3 = sign-extended imm<<2.
- `imm_zext`  out  1: zero-extend imm for src_b = 2; otherwise sign-extend.
- `alu_op`  out  4: drives `ula.OP`.
- `pc_src`  out  2: 0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- `instr_done`  out  1: one-cycle pulse per retired instruction.
- `instr_count`  out  CNT_W: retired-instruction count.
- `halted`  out  1: sticky; set on illegal instruction.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM_RD, MEM_WR, WB_LD, BRANCH, JUMP, HALT.
- ALU codes: SLL 0, SRL 1, SRA 2, SLLV 3, SRLV 4, SRAV 5, ADD 6, SUB 7, AND 8, OR 9, XOR A, NOR B, SLT C, SLTU D, LUI E, ORI F.
- IDLE: all outputs 0. Moves to FETCH on the first cycle after reset release.
- FETCH: `mem_req=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=1`, `alu_op=ADD`. Stays until `mem_ack`. In the `mem_ack` cycle, assert `ir_write` and `pc_write` with `pc_src=0`, then go to DECODE.
- DECODE: `alu_src_a=0`, `alu_src_b=3`, `alu_op=ADD` (branch target into ALUOut). Dispatch on opcode:
  - 0x00 → EXEC_R
  - 0x08/09/0A/0B/0C/0D/0E/0F → EXEC_I
  - 0x23/0x2B → ADDR
  - 0x04/05 → BRANCH
  - 0x02 → JUMP
  - anything else → HALT
- EXEC_R: `alu_src_a=1`, `alu_src_b=0`. Funct map:
  - 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV
  - 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU
  - Unlisted funct → HALT.
- WB_R: `reg_write=1`, `reg_dst=1`, `mem_to_reg=0`; retire.
- EXEC_I: `alu_src_a=1`, `alu_src_b=2`. Opcode map:
  - 08/09 ADD, 0A SLT, 0B SLTU
  - 0C AND, 0D OR, 0E XOR, each with `imm_zext=1`
  - 0F LUI
- WB_I: `reg_write=1`, `reg_dst=0`, `mem_to_reg=0`; retire.
- ADDR: `alu_src_a=1`, `alu_src_b=2`, `alu_op=ADD`. Go to MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: `mem_req=1`, `iord=1`, `mem_we=0`; go to WB_LD on `mem_ack`.
- MEM_WR: same with `mem_we=1`; retire on `mem_ack`.
- WB_LD: `reg_write=1`, `reg_dst=0`, `mem_to_reg=1`; retire.
- BRANCH: `alu_src_a=1`, `alu_src_b=0`, `alu_op=SUB`. `pc_write=zero` for 0x04, `!zero` for 0x05, with `pc_src=1`. Always retire.
- JUMP: `pc_write=1`, `pc_src=2`; retire.
- Retire means: pulse `instr_done`, increment `instr_count` (wraps modulo 2^CNT_W), next state FETCH.
- HALT: absorbing. `halted=1`, all strobes 0, counter frozen. Only reset leaves it.

## Timing
- All outputs are combinational from the state register and the inputs; no output registers.
- Reset values: state IDLE, `instr_count=0`, `halted=0`, every output 0.
- Cycles with zero-wait memory (FETCH ack in first cycle):
  - R-type and I-ALU: 4
  - lw: 5
  - sw: 4
  - beq/bne/j: 3
- Each cycle of `mem_ack` delay adds one cycle in FETCH or MEM_*.
- `mem_req` stays high and address/we stay stable every cycle until `mem_ack`.
- `mem_ack` outside FETCH/MEM_* is ignored.
- Asserting `rst_n` low mid-access drops `mem_req` immediately (asynchronously). No partial retire occurs.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state enum
  - ALU op constants (shared with `ula` callers)
  - opcode and funct constants
  - `alu_src_b` and `pc_src` encodings
- One sub-module, `alu_op_decode`: combinational funct/opcode → `alu_op` / `imm_zext` / illegal flag, used by EXEC_R and EXEC_I.

## Test plan
- Reset: hold `rst_n=0` 3 cycles → all outputs 0. One cycle after release, FETCH with `mem_req=1`, `alu_op=6`.
- `add` (opcode 00, funct 20), `mem_ack` immediate → EXEC_R `alu_op=6`. `instr_done` in cycle 4, `instr_count=1`.
- `lw` with `mem_ack` delayed 3 cycles in MEM_RD → `mem_req` held 4 cycles with `iord=1`. WB_LD `mem_to_reg=1`; total 8 cycles.
- `beq` with `zero=1` → `pc_write=1`, `pc_src=1`. `bne` with `zero=1` → `pc_write=0`. Both retire in 3 cycles.
- Opcode 0x3F → HALT, `halted=1`. 20 further cycles with `mem_ack` toggling give no strobes and no count change.
- `rst_n` pulsed low during MEM_WR wait → `mem_req` drops in the same cycle; IDLE, count 0.
